dm_subword: RTL
===============

Name: dm_subword

Overview:
Parametrised data memory and successor to the fixed 2K-word DM. It adds byte, half and word stores through per-lane merging, and sign- or zero-extended sub-word loads. Reads are registered behind a valid/ready handshake. Reset clears memory with a one-word-per-cycle sweep rather than a single-cycle clear. It sits in the MEM stage and is driven by the load/store decode.

Parameters:
DEPTH_LOG2, 11, log2 of the number of 32-bit words (default 2048 words, 8 KiB)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be 4-byte aligned

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
addr  in  32  byte address
wdata  in  32  store data; the sub-word is taken from the low bits
pc  in  32  PC of the instruction, used for trace only
rsp_valid  out  1  response pulse for an accepted request
rdata  out  32  extended load data
addr_err  out  1  accepted request was misaligned, out of range or illegal

Behaviour:
- Accept condition: req_valid & req_ready on a rising edge.
- FSM state INIT:
  - Entered on any cycle with reset = 1, including mid-operation; the sweep restarts at word 0.
  - A DEPTH_LOG2-bit counter writes 0 to word[cnt], one word per cycle.
  - req_ready = 0; requests are ignored.
  - After word 2^DEPTH_LOG2-1 is cleared, go to IDLE. Total: 2^DEPTH_LOG2 cycles after reset is released.
- FSM state IDLE: req_ready = 1; every request is accepted, one per cycle, with no stalls.
- Reset values: req_ready = 0, rsp_valid = 0, rdata = 0, addr_err = 0.
- Offset: off = addr - BASE_ADDR; word index = off[DEPTH_LOG2+1:2]; lane = off[1:0].
- Error cases:
  - half with lane[0] = 1;
  - word with lane != 0;
  - size 11;
  - addr < BASE_ADDR, or off >= 4 * 2^DEPTH_LOG2.
- Error response: no memory write; the next cycle gives rsp_valid = 1, addr_err = 1, rdata = 0.
- Store:
  - byte writes wdata[7:0] into lane byte;
  - half writes wdata[15:0] into bytes lane and lane+1;
  - word writes all 4 bytes;
  - other bytes are unchanged.
  - The write occurs on the accept edge.
  - Next cycle: rsp_valid = 1, rdata = 0, addr_err = 0.
- Load:
  - The word is sampled on the accept edge.
  - Next cycle: rsp_valid = 1 and rdata = the selected byte or half, extended per req_signed; word loads return the raw word.
  - Byte order is little-endian: lane 0 = bits [7:0].
- Latency: exactly 1 cycle for all responses. rsp_valid is a 1-cycle pulse per accepted request; back-to-back requests give back-to-back pulses.
- Hold: rdata and addr_err hold their last value while rsp_valid = 0.
- Read-after-write: a load accepted the cycle after a store to the same word returns the merged data. Same-cycle conflicts cannot occur (single port).
- Reset asserted in the same cycle as a request: reset wins; no write and no response.

Optional Feature:
DM_TRACE_EN
- Defined: on each successful store, $display("@%h: *%h <= %h", pc, word-aligned addr, merged 32-bit word). Errors print "@%h: DM addr_err %h" with pc and addr.
- Undefined: no $display and no trace logic; function is identical otherwise.

Test Plan:
- Reset sweep: assert reset for 1 cycle with DEPTH_LOG2 = 4 -> req_ready = 0 for 16 cycles, then 1; a word load of every address returns 0.
- Sub-word stores: sw 0x11223344 @0x8, sb 0xAB @0x9, sh 0xBEEF @0xA; then lw @0x8 -> rdata = 0xBEEFAB44 one cycle after accept.
- Extension: with word 0xBEEFAB44 @0x8, lb @0x9 -> 0xFFFFFFAB; lbu @0x9 -> 0x000000AB; lh @0xA -> 0xFFFFBEEF; lhu @0xA -> 0x0000BEEF.
- Misalignment: sh @0x3, sw @0x6, size 11 @0x0 -> each gives addr_err = 1 and rdata = 0; a following lw @0x0 shows memory unchanged.
- Range and base: BASE_ADDR = 0x1000, DEPTH_LOG2 = 4; lw @0x0FFC and lw @0x1040 -> addr_err = 1; sw @0x103C then lw -> returns the stored data.
- Reset mid-operation: store 0x5 @0x4, assert reset mid-sweep, re-assert reset 3 cycles later -> the sweep restarts (full 2^DEPTH_LOG2 cycles of req_ready = 0); then lw @0x4 -> 0.

Source files
------------

// File: rtl/dm_subword.sv
// ---------------------------------------------------------------------------
// dm_subword - parametrised data memory for the MEM stage
//
// Holds 2^DEPTH_LOG2 32-bit words mapped from byte address BASE_ADDR upward.
// Byte, half and word stores merge into the addressed word lane by lane.
// Loads return the selected byte or half, sign- or zero-extended, or the
// raw word. Every accepted request gets exactly one response pulse one
// cycle later. Misaligned, out-of-range or illegal-size requests do not
// touch memory and respond with addr_err = 1 and rdata = 0.
// After reset the memory is cleared one word per cycle (INIT state), and
// no request is accepted until the sweep has finished.
//
// Parameters:
//   DEPTH_LOG2  log2 of the number of 32-bit words
//   BASE_ADDR   byte address of word 0 (4-byte aligned)
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset (restarts the clear sweep)
//   req_valid   request present
//   req_ready   block can accept a request (registered)
//   req_we      1 = store, 0 = load
//   req_size    00 byte, 01 half, 10 word, 11 illegal
//   req_signed  loads: 1 = sign-extend, 0 = zero-extend
//   addr        byte address
//   wdata       store data, sub-word taken from the low bits
//   pc          instruction PC, only used by the optional trace
//   rsp_valid   one-cycle response pulse per accepted request
//   rdata       extended load data (0 for stores and errors), held otherwise
//   addr_err    accepted request was misaligned, out of range or illegal
//
// Optional feature macro: DM_TRACE_EN
//   When defined, successful stores and errored requests are printed.
//   When undefined, no trace logic exists.
// ---------------------------------------------------------------------------

module dm_subword_chk (
    input logic        clk,
    input logic        reset,
    input logic        accept,
    input logic        rsp_valid,
    input logic        addr_err,
    input logic [31:0] rdata
);

    // A response pulse is only ever produced by an accept on the previous edge.
    a_rsp_after_accept: assert property (@(posedge clk) disable iff (reset)
        rsp_valid |-> $past(accept));

    // Error responses always carry zero data.
    a_err_zero_data: assert property (@(posedge clk) disable iff (reset)
        (rsp_valid && addr_err) |-> (rdata == 32'h0000_0000));

endmodule

module dm_subword #(
    parameter int          DEPTH_LOG2 = 11,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        addr_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // Byte-lane write mask for a store of the given size at the given lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << lane;
            2'b01:   m = 4'b0011 << lane;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Merge store data into the old word; the sub-word is replicated across
    // all lanes so the mask alone picks the destination bytes.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] rep;
        logic [3:0]  m;
        logic [31:0] res;
        case (size)
            2'b00:   rep = {4{data[7:0]}};
            2'b01:   rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        m = lane_mask(size, lane);
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = m[i] ? rep[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

    // Select and extend the load result; lane 0 is bits [7:0].
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        sgn);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (size)
            2'b00:   res = {{24{sgn & b[7]}}, b};
            2'b01:   res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                state_r;
    state_t                state_s;
    logic [DEPTH_LOG2-1:0] cnt_r;
    logic [DEPTH_LOG2-1:0] cnt_s;
    logic                  ready_s;
    logic [31:0]           mem_r [0:DEPTH-1];

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic [31:0]           off_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic [1:0]            lane_s;
    logic                  below_s;
    logic                  beyond_s;
    logic                  misalign_s;
    logic                  err_s;
    logic                  accept_s;
    logic [31:0]           old_word_s;
    logic [31:0]           merged_s;
    logic [31:0]           load_s;

    assign off_s    = addr - BASE_ADDR;
    assign idx_s    = off_s[DEPTH_LOG2+1:2];
    assign lane_s   = off_s[1:0];
    assign below_s  = (addr < BASE_ADDR);
    // Compare in 34 bits so DEPTH_LOG2 up to 30 cannot overflow the bound.
    assign beyond_s = ({2'b00, off_s} >= (34'd1 << (DEPTH_LOG2 + 2)));
    // Reset wins over a simultaneous request.
    assign accept_s = req_valid & req_ready & ~reset;

    // Alignment check per access size; size 11 is always an error.
    always_comb begin
        misalign_s = 1'b0;
        case (req_size)
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = lane_s[0];
            2'b10:   misalign_s = (lane_s != 2'b00);
            default: misalign_s = 1'b1;
        endcase
    end

    assign err_s      = below_s | beyond_s | misalign_s;
    assign old_word_s = mem_r[idx_s];
    assign merged_s   = merge_word(old_word_s, wdata, req_size, lane_s);
    assign load_s     = extract_load(old_word_s, req_size, lane_s, req_signed);

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------

    // State, sweep counter and ready register.
    always_ff @(posedge clk) begin
        state_r   <= state_s;
        cnt_r     <= cnt_s;
        req_ready <= ready_s;
    end

    // Next state: reset restarts the sweep at word 0 from any state.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        if (reset) begin
            state_s = ST_INIT;
            cnt_s   = {DEPTH_LOG2{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    cnt_s = cnt_r + DEPTH_LOG2'(1);
                    if (cnt_r == {DEPTH_LOG2{1'b1}}) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_INIT;
                    end
                end
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_INIT;
                    cnt_s   = {DEPTH_LOG2{1'b0}};
                end
            endcase
        end
        ready_s = (state_s == ST_IDLE);
    end

    // -----------------------------------------------------------------------
    // Memory write port (shared by the clear sweep and stores)
    // -----------------------------------------------------------------------
    logic                  mem_we_s;
    logic [DEPTH_LOG2-1:0] mem_waddr_s;
    logic [31:0]           mem_wdata_s;

    // Select the single write source for this cycle.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = {DEPTH_LOG2{1'b0}};
        mem_wdata_s = 32'h0000_0000;
        if (reset) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_INIT) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_r;
            mem_wdata_s = 32'h0000_0000;
        end else if (accept_s && req_we && !err_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = idx_s;
            mem_wdata_s = merged_s;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array; contents are defined only through the clear sweep.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // -----------------------------------------------------------------------
    // Response
    // -----------------------------------------------------------------------

    // One-cycle response pulse; data and error hold between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rdata     <= 32'h0000_0000;
            addr_err  <= 1'b0;
        end else if (accept_s) begin
            rsp_valid <= 1'b1;
            addr_err  <= err_s;
            rdata     <= (err_s || req_we) ? 32'h0000_0000 : load_s;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef DM_TRACE_EN
    // Trace of successful stores and errored requests.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            if (err_s) begin
                $display("@%h: DM addr_err %h", pc, addr);
            end else if (req_we) begin
                $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged_s);
            end
        end
    end
`else
    logic unused_pc_s;
    assign unused_pc_s = ^pc;
`endif

    dm_subword_chk u_chk (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept_s),
        .rsp_valid (rsp_valid),
        .addr_err  (addr_err),
        .rdata     (rdata)
    );

endmodule
